// File: rtl/rf_pkg.sv
// rtl/rf_pkg.sv - shared constants, address-width helper and types for the register file
package rf_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int DEPTH_DEF  = 32;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  typedef logic [clog2(DEPTH_DEF)-1:0] reg_addr_t;
  typedef logic [DATA_W_DEF-1:0]       reg_data_t;

endpackage

// File: rtl/rf_multiport_if.sv
// rtl/rf_multiport_if.sv - read/write/issue bus between decode, writeback and the register file
interface rf_multiport_if
  import rf_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int NUM_RD = 2,
  parameter int NUM_WR = 2
);
  localparam int AW = clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [NUM_RD-1:0][AW-1:0]     rd_addr;
  logic [NUM_RD-1:0][DATA_W-1:0] rd_data;
  logic [NUM_RD-1:0]             rd_pend;
  logic [NUM_WR-1:0]             wr_en;
  logic [NUM_WR-1:0][AW-1:0]     wr_addr;
  logic [NUM_WR-1:0][DATA_W-1:0] wr_data;
  logic [NUM_WR-1:0]             wr_clr;
  logic                          iss_en;
  logic [AW-1:0]                 iss_addr;
  logic [CW-1:0]                 pend_cnt;

  modport master (
    output rd_addr, wr_en, wr_addr, wr_data, wr_clr, iss_en, iss_addr,
    input  rd_data, rd_pend, pend_cnt
  );

  modport slave (
    input  rd_addr, wr_en, wr_addr, wr_data, wr_clr, iss_en, iss_addr,
    output rd_data, rd_pend, pend_cnt
  );

endinterface

// File: rtl/rf_scoreboard.sv
// rtl/rf_scoreboard.sv - per-register pending bits with set-over-clear priority and a registered popcount
module rf_scoreboard
  import rf_pkg::*;
#(
  parameter  int DEPTH  = DEPTH_DEF,
  parameter  int NUM_WR = 2,
  localparam int AW     = clog2(DEPTH),
  localparam int CW     = AW + 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      iss_en,
  input  logic [AW-1:0]             iss_addr,
  input  logic [NUM_WR-1:0]         wr_en,
  input  logic [NUM_WR-1:0]         wr_clr,
  input  logic [NUM_WR-1:0][AW-1:0] wr_addr,
  output logic [DEPTH-1:0]          pend,
  output logic [CW-1:0]             pend_cnt
);

  logic [DEPTH-1:0] clr_mask;
  logic [DEPTH-1:0] set_mask;
  logic [DEPTH-1:0] pend_nxt;
  logic [CW-1:0]    cnt_nxt;

  always_comb begin
    clr_mask = '0;
    set_mask = '0;
    for (int j = 0; j < NUM_WR; j++) begin
      if (wr_en[j] && wr_clr[j]) clr_mask[wr_addr[j]] = 1'b1;
    end
    if (iss_en) set_mask[iss_addr] = 1'b1;
    // A fresh issue overrides a retire of the older producer in the same cycle.
    pend_nxt = (pend & ~clr_mask) | set_mask;
    cnt_nxt  = '0;
    for (int k = 0; k < DEPTH; k++) begin
      cnt_nxt = cnt_nxt + CW'(pend_nxt[k]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend     <= '0;
      pend_cnt <= '0;
    end else begin
      pend     <= pend_nxt;
      pend_cnt <= cnt_nxt;
    end
  end

endmodule

// File: rtl/rf_multiport.sv
// rtl/rf_multiport.sv - multi-port register file with write bypass, write priority and RAW scoreboard
module rf_multiport
  import rf_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int DEPTH    = DEPTH_DEF,
  parameter int NUM_RD   = 2,
  parameter int NUM_WR   = 2,
  parameter int ZERO_REG = 1
) (
  input logic           clk,
  input logic           rst_n,
  rf_multiport_if.slave bus
);

  localparam int AW = clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]  pend;
  logic              iss_ok;

  // Later ports overwrite earlier ones, so the highest enabled index wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < DEPTH; k++) mem[k] <= '0;
    end else begin
      for (int j = 0; j < NUM_WR; j++) begin
        if (bus.wr_en[j] && !(ZERO_REG != 0 && bus.wr_addr[j] == '0))
          mem[bus.wr_addr[j]] <= bus.wr_data[j];
      end
    end
  end

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [DATA_W-1:0] rd_val;

    always_comb begin
      rd_val = mem[bus.rd_addr[i]];
      for (int j = 0; j < NUM_WR; j++) begin
        if (bus.wr_en[j] && bus.wr_addr[j] == bus.rd_addr[i]) rd_val = bus.wr_data[j];
      end
      if (!rst_n || (ZERO_REG != 0 && bus.rd_addr[i] == '0)) rd_val = '0;
    end

    assign bus.rd_data[i] = rd_val;
    assign bus.rd_pend[i] = pend[bus.rd_addr[i]];
  end

  assign iss_ok = bus.iss_en && !(ZERO_REG != 0 && bus.iss_addr == '0);

  rf_scoreboard #(
    .DEPTH  (DEPTH),
    .NUM_WR (NUM_WR)
  ) u_scoreboard (
    .clk      (clk),
    .rst_n    (rst_n),
    .iss_en   (iss_ok),
    .iss_addr (bus.iss_addr),
    .wr_en    (bus.wr_en),
    .wr_clr   (bus.wr_clr),
    .wr_addr  (bus.wr_addr),
    .pend     (pend),
    .pend_cnt (bus.pend_cnt)
  );

endmodule

// File: tb/tb_rf_multiport.sv
// tb/tb_rf_multiport.sv - directed vector bench for rf_multiport
module tb_rf_multiport;
  import rf_pkg::*;

  localparam int DW  = 32;
  localparam int DEP = 32;
  localparam int NR  = 2;
  localparam int NW  = 2;
  localparam int NV  = 16;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  rf_multiport_if #(.DATA_W(DW), .DEPTH(DEP), .NUM_RD(NR), .NUM_WR(NW)) bus ();

  rf_multiport #(
    .DATA_W(DW), .DEPTH(DEP), .NUM_RD(NR), .NUM_WR(NW), .ZERO_REG(1)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  typedef struct {
    logic [1:0]        we;
    logic [1:0][4:0]   wa;
    logic [1:0][31:0]  wd;
    logic [1:0]        wc;
    logic              ie;
    logic [4:0]        ia;
    logic [1:0][4:0]   ra;
    logic [1:0][31:0]  ed;
    logic [1:0]        ep;
    logic [5:0]        ec;
  } vec_t;

  vec_t vt [NV];
  int   checks = 0;
  int   errors = 0;

  function automatic vec_t mk(
    input logic [1:0] we, input logic [4:0] wa0, input logic [31:0] wd0,
    input logic [4:0] wa1, input logic [31:0] wd1, input logic [1:0] wc,
    input logic ie, input logic [4:0] ia, input logic [4:0] ra0, input logic [4:0] ra1,
    input logic [31:0] ed0, input logic [31:0] ed1, input logic [1:0] ep, input logic [5:0] ec);
    vec_t v;
    v.we = we; v.wa[0] = wa0; v.wd[0] = wd0; v.wa[1] = wa1; v.wd[1] = wd1;
    v.wc = wc; v.ie = ie; v.ia = ia; v.ra[0] = ra0; v.ra[1] = ra1;
    v.ed[0] = ed0; v.ed[1] = ed1; v.ep = ep; v.ec = ec;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    bus.wr_en    = v.we;
    bus.wr_addr  = v.wa;
    bus.wr_data  = v.wd;
    bus.wr_clr   = v.wc;
    bus.iss_en   = v.ie;
    bus.iss_addr = v.ia;
    bus.rd_addr  = v.ra;
  endtask

  task automatic idle();
    bus.wr_en  = '0;
    bus.wr_clr = '0;
    bus.iss_en = 1'b0;
  endtask

  initial begin
    //           we     wa0 wd0           wa1 wd1           wc     ie    ia  ra0 ra1 ed0           ed1           ep     ec
    vt[0]  = mk(2'b01, 7,  32'h12345678, 0,  32'h0,        2'b00, 1'b0, 0,  0,  7,  32'h0,        32'h12345678, 2'b00, 0);
    vt[1]  = mk(2'b00, 0,  32'h0,        0,  32'h0,        2'b00, 1'b0, 0,  7,  7,  32'h12345678, 32'h12345678, 2'b00, 0);
    vt[2]  = mk(2'b11, 3,  32'hAAAA0000, 3,  32'h5555FFFF, 2'b00, 1'b0, 0,  3,  7,  32'h5555FFFF, 32'h12345678, 2'b00, 0);
    vt[3]  = mk(2'b00, 0,  32'h0,        0,  32'h0,        2'b00, 1'b0, 0,  3,  0,  32'h5555FFFF, 32'h0,        2'b00, 0);
    vt[4]  = mk(2'b11, 0,  32'hFFFFFFFF, 0,  32'hFFFFFFFF, 2'b00, 1'b1, 0,  0,  0,  32'h0,        32'h0,        2'b00, 0);
    vt[5]  = mk(2'b00, 0,  32'h0,        0,  32'h0,        2'b00, 1'b0, 0,  0,  0,  32'h0,        32'h0,        2'b00, 0);
    vt[6]  = mk(2'b00, 0,  32'h0,        0,  32'h0,        2'b00, 1'b1, 9,  9,  3,  32'h0,        32'h5555FFFF, 2'b00, 0);
    vt[7]  = mk(2'b00, 0,  32'h0,        0,  32'h0,        2'b00, 1'b0, 0,  9,  9,  32'h0,        32'h0,        2'b11, 1);
    vt[8]  = mk(2'b01, 9,  32'h00000099, 0,  32'h0,        2'b01, 1'b1, 9,  9,  0,  32'h00000099, 32'h0,        2'b01, 1);
    vt[9]  = mk(2'b00, 0,  32'h0,        0,  32'h0,        2'b00, 1'b0, 0,  9,  9,  32'h00000099, 32'h00000099, 2'b11, 1);
    vt[10] = mk(2'b10, 0,  32'h0,        9,  32'h00000001, 2'b10, 1'b0, 0,  9,  7,  32'h00000001, 32'h12345678, 2'b01, 1);
    vt[11] = mk(2'b00, 0,  32'h0,        0,  32'h0,        2'b00, 1'b0, 0,  9,  9,  32'h00000001, 32'h00000001, 2'b00, 0);
    vt[12] = mk(2'b01, 4,  32'h00000044, 0,  32'h0,        2'b01, 1'b0, 0,  0,  4,  32'h0,        32'h00000044, 2'b00, 0);
    vt[13] = mk(2'b00, 0,  32'h0,        0,  32'h0,        2'b00, 1'b0, 0,  4,  4,  32'h00000044, 32'h00000044, 2'b00, 0);
    vt[14] = mk(2'b11, 1,  32'h00000011, 2,  32'h00000022, 2'b00, 1'b0, 0,  2,  1,  32'h00000022, 32'h00000011, 2'b00, 0);
    vt[15] = mk(2'b00, 0,  32'h0,        0,  32'h0,        2'b00, 1'b0, 0,  1,  2,  32'h00000011, 32'h00000022, 2'b00, 0);

    rst_n        = 1'b0;
    bus.wr_en    = '0;
    bus.wr_addr  = '0;
    bus.wr_data  = '0;
    bus.wr_clr   = '0;
    bus.iss_en   = 1'b0;
    bus.iss_addr = '0;
    bus.rd_addr  = '0;
    bus.rd_addr[0] = 5'd7;
    bus.rd_addr[1] = 5'd9;
    #11;
    check("rst_rd_data0", bus.rd_data[0], 32'h0);
    check("rst_rd_data1", bus.rd_data[1], 32'h0);
    check("rst_rd_pend", 32'(bus.rd_pend), 32'h0);
    check("rst_pend_cnt", 32'(bus.pend_cnt), 32'h0);
    #1 rst_n = 1'b1;

    for (int n = 0; n < NV; n++) begin
      @(negedge clk);
      drive(vt[n]);
      #2;
      check($sformatf("v%0d_rd_data0", n), bus.rd_data[0], vt[n].ed[0]);
      check($sformatf("v%0d_rd_data1", n), bus.rd_data[1], vt[n].ed[1]);
      check($sformatf("v%0d_rd_pend", n), 32'(bus.rd_pend), 32'(vt[n].ep));
      check($sformatf("v%0d_pend_cnt", n), 32'(bus.pend_cnt), 32'(vt[n].ec));
    end

    // Fill the scoreboard with every nonzero register.
    for (int k = 1; k < DEP; k++) begin
      @(negedge clk);
      idle();
      bus.iss_en   = 1'b1;
      bus.iss_addr = 5'(k);
      #2 check("fill_cnt", 32'(bus.pend_cnt), 32'(k - 1));
    end
    @(negedge clk);
    idle();
    bus.rd_addr[0] = 5'd31;
    bus.rd_addr[1] = 5'd0;
    #2;
    check("fill_cnt_full", 32'(bus.pend_cnt), 32'd31);
    check("fill_pend", 32'(bus.rd_pend), 32'h1);

    // Retire two per cycle; the last cycle retires r31 on both ports.
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      bus.wr_en  = 2'b11;
      bus.wr_clr = 2'b11;
      bus.wr_addr[0] = 5'(2 * k + 1);
      bus.wr_addr[1] = (k == 15) ? 5'd31 : 5'(2 * k + 2);
      bus.wr_data[0] = 32'h0;
      bus.wr_data[1] = 32'h0;
      #2 check("drain_cnt", 32'(bus.pend_cnt), 32'(31 - 2 * k));
    end
    @(negedge clk);
    idle();
    #2;
    check("drain_cnt_zero", 32'(bus.pend_cnt), 32'd0);
    check("drain_pend", 32'(bus.rd_pend), 32'h0);

    // Asynchronous reset between edges.
    @(negedge clk);
    bus.wr_en      = 2'b01;
    bus.wr_addr[0] = 5'd5;
    bus.wr_data[0] = 32'hDEADBEEF;
    bus.iss_en     = 1'b1;
    bus.iss_addr   = 5'd12;
    @(negedge clk);
    idle();
    bus.rd_addr[0] = 5'd5;
    bus.rd_addr[1] = 5'd12;
    #2;
    check("pre_rst_r5", bus.rd_data[0], 32'hDEADBEEF);
    check("pre_rst_pend", 32'(bus.rd_pend), 32'h2);
    check("pre_rst_cnt", 32'(bus.pend_cnt), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("mid_rst_r5", bus.rd_data[0], 32'h0);
    check("mid_rst_pend", 32'(bus.rd_pend), 32'h0);
    check("mid_rst_cnt", 32'(bus.pend_cnt), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #2;
    check("post_rst_r5", bus.rd_data[0], 32'h0);
    @(negedge clk);
    bus.wr_en      = 2'b10;
    bus.wr_addr[1] = 5'd6;
    bus.wr_data[1] = 32'h00000066;
    bus.iss_en     = 1'b1;
    bus.iss_addr   = 5'd6;
    @(negedge clk);
    idle();
    bus.rd_addr[0] = 5'd6;
    bus.rd_addr[1] = 5'd6;
    #2;
    check("first_edge_r6", bus.rd_data[0], 32'h00000066);
    check("first_edge_pend", 32'(bus.rd_pend), 32'h3);
    check("first_edge_cnt", 32'(bus.pend_cnt), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rf_multiport.md
# rf_multiport

Parametrised multi-port general-purpose register file for the MIPS datapath, succeeding the single-write/dual-read file. It provides NUM_RD combinational read ports with same-cycle write-to-read bypass and NUM_WR synchronous write ports with fixed priority. It also keeps a per-register pending scoreboard that the decode stage uses for RAW hazard detection. It sits between decode (reads, issue) and writeback (writes).

## Interface
- DATA_W, 32: register width in bits
- DEPTH, 32: number of architectural registers; power of two, ≥ 2
- NUM_RD, 2: read ports
- NUM_WR, 2: write ports
- ZERO_REG, 1: 1 = register 0 reads as zero and ignores writes
- clk  input  1  clock, rising edge active
- rst_n  input  1  asynchronous, active-low reset
- rd_addr  input  NUM_RD×AW  read addresses, with AW = clog2(DEPTH)
- rd_data  output  NUM_RD×DATA_W  read data
- rd_pend  output  NUM_RD  pending bit of each addressed register
- wr_en  input  NUM_WR  write enables
- wr_addr  input  NUM_WR×AW  write addresses
- wr_data  input  NUM_WR×DATA_W  write data
- wr_clr  input  NUM_WR  this write retires the pending producer
- iss_en  input  1  issue: mark iss_addr pending
- iss_addr  input  AW  destination register of the issued instruction
- pend_cnt  output  clog2(DEPTH)+1  number of registers currently pending

## Operation
- All storage writes on the rising edge of clk. No negedge logic.
- Reset (rst_n low, asynchronous): all registers are 0 and all pending bits are 0. Outputs during reset: rd_data = 0, rd_pend = 0, pend_cnt = 0.
- Read: rd_data[i] is the stored value of rd_addr[i], or a bypassed value.
- Bypass: if any wr_en[j] && wr_addr[j] == rd_addr[i], rd_data[i] = wr_data of the highest such j. Combinational, same cycle.
- Write conflict: several enabled ports to the same address → the highest port index wins, both in storage and in bypass.
- ZERO_REG = 1: address 0 reads 0 regardless of writes or bypass. Writes to 0 are discarded. iss_en to 0 is ignored, so the pending bit of register 0 is always 0.
- Scoreboard bits pend[DEPTH]:
  - set on iss_en at iss_addr;
  - cleared by any wr_en[j] && wr_clr[j] at wr_addr[j].
- Simultaneous set and clear of the same register: set wins (a new producer was issued).
- A clear of a register that is not pending is a no-op. A set of a register that is already pending stays at 1.
- rd_pend[i] reflects the registered pend state. It is not bypassed: a same-cycle clear is not visible until the next cycle.
- pend_cnt is registered. It equals the popcount of pend and updates in the same edge as pend.
- Address width: addresses ≥ DEPTH cannot occur (AW exact). There are no other error conditions.

## Timing
- Read latency: 0 cycles (combinational from rd_addr, wr_*).
- Write latency: 1 edge. A value written at edge N is readable from storage after edge N, and is visible via bypass in the cycle before edge N.
- Scoreboard: iss_en in cycle N → rd_pend = 1 from cycle N+1. A clear in cycle N → rd_pend = 0 from cycle N+1, unless iss_en also targets that register in cycle N.
- Reset assertion mid-operation clears all state immediately. On deassertion, the first active edge accepts writes and issues.
- Critical path: rd_addr → compare against NUM_WR write addresses → data mux. No clock-to-out paths other than rd_pend and pend_cnt.

## Structure
- Package rf_pkg:
  - default DATA_W and DEPTH constants;
  - AW function clog2;
  - typedef reg_addr_t;
  - typedef reg_data_t.
- Sub-module rf_scoreboard: the pend vector, set/clear priority, and pend_cnt register. It is instantiated once, with DEPTH and NUM_WR parameters.
- The top level holds the storage array, the write-priority logic, and the per-read-port bypass mux (generate loop over NUM_RD).

## Test plan
- Reset: write 0xDEADBEEF to r5, then assert rst_n low asynchronously between edges. Required: rd_data of r5 = 0 immediately, pend_cnt = 0.
- Bypass: write port 0 writes r7 = 0x12345678 while read port 1 reads r7. Required: rd_data[1] = 0x12345678 in the same cycle, and the value is still read after the edge.
- Write conflict: ports 0 and 1 write r3 with 0xAAAA0000 and 0x5555FFFF in the same cycle. Required: 0x5555FFFF is both bypassed and stored.
- Zero register: write 0xFFFFFFFF to r0 and issue r0. Required: reads of r0 = 0, rd_pend = 0, pend_cnt unchanged.
- Scoreboard set-wins: issue r9 in cycle 1, then in cycle 3 issue r9 and retire r9 (wr_clr) together. Required: rd_pend for r9 = 1 in cycles 2–4, and pend_cnt = 1 throughout.
- Count wrap: issue all DEPTH−1 nonzero registers. Required: pend_cnt = 31. Then retire all via both write ports at two per cycle. Required: pend_cnt reaches 0 after 16 cycles.
